button_debouncer: RTL and testbench

//  Conditions raw board pushbuttons/switches before the Avalon PIO input port with falling-edge capture.
//  Per channel: 2-FF synchroniser, then a stability counter. Output changes only after STABLE_CYCLES consecutive equal samples.

---
 rtl/button_debouncer_pkg.sv | 25 ++
 rtl/button_debouncer_channel.sv | 101 ++++++++++
 rtl/button_debouncer.sv | 48 ++++
 tb/tb_button_debouncer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the pushbutton debouncer:
//   db_state_t           per-channel FSM state encoding
//   DB_STABLE_1MS_50MHZ  stability window of 1 ms at a 50 MHz clock
//   db_params_ok()       parameter legality check used at elaboration
// ---------------------------------------------------------------------------
package button_debouncer_pkg;

  typedef enum logic {
    DB_IDLE     = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_t;

  localparam int DB_STABLE_1MS_50MHZ = 50000;

  // The counter has to reach STABLE_CYCLES-1, so 2**cnt_w must cover
  // STABLE_CYCLES, and the window must be at least one sample long.
  function automatic bit db_params_ok(input int stable_cycles, input int cnt_w);
    longint span;
    span = longint'(1) << cnt_w;
    return (stable_cycles >= 1) && (cnt_w >= 1) && (span >= longint'(stable_cycles));
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounced bit: 2-FF synchroniser, stability counter, 2-state FSM and
// registered rise/fall strobes.
//
// state       | meaning
// ------------+------------------------------------------------------------
// DB_IDLE     | synchronised input equals clean level, counter held at 0
// DB_SETTLING | input differs from clean level, counting equal samples
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   raw         in   asynchronous raw pin
//   clean       out  debounced level (registered)
//   fall_pulse  out  1-cycle strobe on clean 1->0
//   rise_pulse  out  1-cycle strobe on clean 0->1
// ---------------------------------------------------------------------------
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = DB_STABLE_1MS_50MHZ,
  parameter int   CNT_W         = 16,
  parameter logic RESET_BIT     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic fall_pulse,
  output logic rise_pulse
);

  if (!db_params_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_params
    $error("debounce_channel: need 1 <= STABLE_CYCLES <= 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1         <= RESET_BIT;
      s2         <= RESET_BIT;
      clean      <= RESET_BIT;
      cnt        <= '0;
      state      <= DB_IDLE;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      // Strobes live for exactly one cycle unless re-asserted below.
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;

      case (state)
        DB_IDLE: begin
          if (s2 != clean) begin
            if (STABLE_CYCLES == 1) begin
              // A single differing sample is already a full window.
              clean      <= s2;
              fall_pulse <= ~s2;
              rise_pulse <= s2;
            end else begin
              state <= DB_SETTLING;
              cnt   <= CNT_ONE;
            end
          end
        end

        DB_SETTLING: begin
          if (s2 == clean) begin
            // Bounced back before the window completed: discard.
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            clean      <= s2;
            fall_pulse <= ~s2;
            rise_pulse <= s2;
            cnt        <= '0;
            state      <= DB_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Conditions raw pushbuttons/switches for a PIO in_port with edge capture.
// Each bit is an independent debounce_channel; clean_out changes only after
// STABLE_CYCLES consecutive synchronised samples differ from it, so the PIO
// sees one edge per physical press. Reset to RESET_VALUE (idle-high buttons)
// avoids a spurious falling edge at reset release.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   raw_in      in   [WIDTH] asynchronous raw pins, may bounce
//   clean_out   out  [WIDTH] debounced level, registered
//   fall_pulse  out  [WIDTH] 1-cycle strobe per bit on clean 1->0
//   rise_pulse  out  [WIDTH] 1-cycle strobe per bit on clean 0->1
// ---------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STABLE_CYCLES = DB_STABLE_1MS_50MHZ,
  parameter int               CNT_W         = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] rise_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_in[i]),
      .clean      (clean_out[i]),
      .fall_pulse (fall_pulse[i]),
      .rise_pulse (rise_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int S0 = 4;   // main build
  localparam int S1 = 1;   // single-sample build

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_in = 8'hFF;

  logic [7:0] clean0, fall0, rise0;
  logic [7:0] clean1, fall1, rise1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .WIDTH(8), .STABLE_CYCLES(S0), .CNT_W(3), .RESET_VALUE(8'hFF)
  ) dut (
    .clk(clk), .reset(rst), .raw_in(raw_in),
    .clean_out(clean0), .fall_pulse(fall0), .rise_pulse(rise0)
  );

  button_debouncer #(
    .WIDTH(8), .STABLE_CYCLES(S1), .CNT_W(1), .RESET_VALUE(8'hFF)
  ) dut1 (
    .clk(clk), .reset(rst), .raw_in(raw_in),
    .clean_out(clean1), .fall_pulse(fall1), .rise_pulse(rise1)
  );

  // Behavioural model: a level is accepted once the last S samples seen
  // after the two-stage synchroniser all differ from the current level.
  logic [7:0] m_p1    [2];
  logic [7:0] m_p2    [2];
  logic [7:0] m_clean [2];
  logic [7:0] m_fall  [2];
  logic [7:0] m_rise  [2];
  logic [7:0] hist    [2][4];   // hist[k][0] = most recent sample

  function automatic int win(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_p1[k] = 8'hFF; m_p2[k] = 8'hFF; m_clean[k] = 8'hFF;
        m_fall[k] = 8'h00; m_rise[k] = 8'h00;
        for (int j = 0; j < 4; j++) hist[k][j] = 8'hFF;
      end else begin
        logic [7:0] nc;
        for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = m_p2[k];
        nc = m_clean[k];
        for (int b = 0; b < 8; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < win(k); j++)
            if (hist[k][j][b] == m_clean[k][b]) all_diff = 1'b0;
          if (all_diff) nc[b] = ~m_clean[k][b];
        end
        m_fall[k]  = m_clean[k] & ~nc;
        m_rise[k]  = ~m_clean[k] & nc;
        m_clean[k] = nc;
        m_p2[k]    = m_p1[k];
        m_p1[k]    = raw_in;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("clean0", clean0, m_clean[0]);
    chk("fall0",  fall0,  m_fall[0]);
    chk("rise0",  rise0,  m_rise[0]);
    chk("excl0",  fall0 & rise0, 8'h00);
    chk("clean1", clean1, m_clean[1]);
    chk("fall1",  fall1,  m_fall[1]);
    chk("rise1",  rise1,  m_rise[1]);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] v);
    #1 raw_in = v;
  endtask

  initial begin
    // 1: reset release with idle-high inputs
    wait_n(3);
    #1 rst = 1'b0;
    wait_n(20);
    chk("t1_clean", clean0, 8'hFF);
    chk("t1_fall",  fall0,  8'h00);
    chk("t1_rise",  rise0,  8'h00);

    // 2: press and release channel 0
    drive(8'hFE);
    wait_n(5);  chk("t2_before", clean0, 8'hFF);
    wait_n(1);  chk("t2_clean", clean0, 8'hFE); chk("t2_fall", fall0, 8'h01);
    wait_n(1);  chk("t2_fall_end", fall0, 8'h00);
    drive(8'hFF);
    wait_n(5);  chk("t2_rise_early", rise0, 8'h00);
    wait_n(1);  chk("t2_rise", rise0, 8'h01); chk("t2_clean_up", clean0, 8'hFF);
    wait_n(1);  chk("t2_rise_end", rise0, 8'h00);

    // 3: bounce on channel 3, three low samples at a time
    for (int r = 0; r < 5; r++) begin
      drive(8'hF7); wait_n(3);
      drive(8'hFF); wait_n(1);
    end
    wait_n(10);
    chk("t3_clean", clean0, 8'hFF);

    // 4: many channels at once
    drive(8'h5A);
    wait_n(5);  chk("t4_before", clean0, 8'hFF);
    wait_n(1);  chk("t4_clean", clean0, 8'h5A); chk("t4_fall", fall0, 8'hA5);
                chk("t4_rise", rise0, 8'h00);
    wait_n(1);  chk("t4_fall_end", fall0, 8'h00);
    drive(8'hFF);
    wait_n(10);

    // 5: reset while channel 2 is mid-window
    drive(8'hFB);
    wait_n(4);
    #2 rst = 1'b1;
    #1;
    chk("t5_clean0", clean0, 8'hFF);
    chk("t5_clean1", clean1, 8'hFF);
    chk("t5_fall0",  fall0,  8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_n(5);  chk("t5_relatency", clean0, 8'hFF);
    wait_n(1);  chk("t5_clean", clean0, 8'hFB); chk("t5_fall", fall0, 8'h04);
    drive(8'hFF);
    wait_n(10);

    // 6: single-sample build on channel 7
    drive(8'h7F);
    wait_n(2);  chk("t6_before", clean1, 8'hFF);
    wait_n(1);  chk("t6_clean", clean1, 8'h7F); chk("t6_fall", fall1, 8'h80);
    wait_n(1);  chk("t6_fall_end", fall1, 8'h00);
    drive(8'hFF);
    wait_n(10);

    // Randomised phase: alternate calm and noisy stretches, occasional reset
    begin
      logic [7:0] v;
      int         p_toggle;
      v = 8'hFF;
      p_toggle = 2;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        #1;
        if (c % 64 == 0) p_toggle = ($urandom_range(0, 2) == 0) ? 40 : 2;
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 99) < p_toggle) v[b] = ~v[b];
        raw_in = v;
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      end
      rst = 1'b0;
    end
    wait_n(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
